// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the CPU state slice: datapath width,
//                canonical NOP and HALT encodings, sequential PC step.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          XLEN       = 32;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : Word-addressed data memory. Combinational read, synchronous
//                write, synchronous reset that clears every word.
//  Ports       : clock      - rising-edge clock
//                reset      - synchronous active-high, clears all words
//                we         - write enable
//                index      - word index
//                write_data - word to store
//                read_data  - word at index, same cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import cpu_pkg::*;
#(
    parameter int DMEM_DEPTH = 64,
    parameter int AW         = $clog2(DMEM_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   index,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data
);

    logic [XLEN-1:0] memory [DMEM_DEPTH];

    // Reset clears the whole array and takes precedence over a write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                memory[i] <= '0;
            end
        end else if (we) begin
            memory[index] <= write_data;
        end
    end

    // Read shows the stored value; a write in this cycle appears after the edge.
    assign read_data = memory[index];

endmodule : dmem_array
`default_nettype wire

// File: rtl/cpu_state_core.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_state_core
//  Description : Architectural state of a small RV32 core: program counter
//                with halt/jump/branch redirect, instruction register and a
//                word-indexed data memory.
//  Ports       : clock, reset (sync, active-high)
//                is_halt, is_jal, is_jalr, branch_taken - PC control
//                branch_target, jalr_target, imm_j      - redirect operands
//                program_counter_value                  - current PC
//                instruction_in / instruction_out       - IR load / contents
//                memory_we, address, write_data, read_data - data memory
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_state_core
    import cpu_pkg::*;
#(
    parameter int          DMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IR_RESET   = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        is_halt,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] imm_j,
    output logic [31:0] program_counter_value,
    input  logic [31:0] instruction_in,
    output logic [31:0] instruction_out,
    input  logic        memory_we,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int c_AW = $clog2(DMEM_DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;
    logic [XLEN-1:0] w_pc_next;
    logic [c_AW-1:0] w_index;
    logic            w_unused_addr;

    // Halt outranks every redirect; jal outranks jalr and branch.
    // All sums wrap modulo 2^32 by construction of the 32-bit width.
    always_comb begin
        w_pc_next = r_pc + PC_STEP;
        if (is_halt) begin
            w_pc_next = r_pc;
        end else if (is_jal) begin
            w_pc_next = r_pc + imm_j;
        end else if (is_jalr) begin
            w_pc_next = jalr_target & ~32'd1;
        end else if (branch_taken) begin
            w_pc_next = branch_target;
        end
    end

    // IR has no enable: it follows instruction_in even while halted.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= RESET_PC;
            r_ir <= IR_RESET;
        end else begin
            r_pc <= w_pc_next;
            r_ir <= instruction_in;
        end
    end

    assign program_counter_value = r_pc;
    assign instruction_out       = r_ir;

    // Upper address bits alias onto the same words.
    assign w_index       = address[c_AW-1:0];
    assign w_unused_addr = ^address[XLEN-1:c_AW];

    dmem_array #(
        .DMEM_DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .clock      (clock),
        .reset      (reset),
        .we         (memory_we),
        .index      (w_index),
        .write_data (write_data),
        .read_data  (read_data)
    );

endmodule : cpu_state_core
`default_nettype wire

// File: tb/tb_cpu_state_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_state_core
//  Description : Directed self-checking bench for cpu_state_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_state_core;

    logic        clock;
    logic        reset;
    logic        is_halt;
    logic        is_jal;
    logic        is_jalr;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] imm_j;
    logic [31:0] program_counter_value;
    logic [31:0] instruction_in;
    logic [31:0] instruction_out;
    logic        memory_we;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int n_total = 0;
    int n_bad   = 0;

    cpu_state_core #(
        .DMEM_DEPTH (64),
        .RESET_PC   (32'h0000_0000),
        .IR_RESET   (32'h0000_0013)
    ) u_dut (
        .clock                 (clock),
        .reset                 (reset),
        .is_halt               (is_halt),
        .is_jal                (is_jal),
        .is_jalr               (is_jalr),
        .branch_taken          (branch_taken),
        .branch_target         (branch_target),
        .jalr_target           (jalr_target),
        .imm_j                 (imm_j),
        .program_counter_value (program_counter_value),
        .instruction_in        (instruction_in),
        .instruction_out       (instruction_out),
        .memory_we             (memory_we),
        .address               (address),
        .write_data            (write_data),
        .read_data             (read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        is_halt       = 1'b0;
        is_jal        = 1'b0;
        is_jalr       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jalr_target   = 32'h0;
        imm_j         = 32'h0;
        memory_we     = 1'b0;
        write_data    = 32'h0;
    endtask

    initial begin
        idle_inputs();
        reset          = 1'b1;
        instruction_in = 32'h0000_0013;
        address        = 32'd6;

        // Reset state
        step();
        check("rst_pc", program_counter_value, 32'h0);
        check("rst_ir", instruction_out, 32'h0000_0013);
        check("rst_mem6", read_data, 32'h0);

        // Sequential fetch
        reset = 1'b0;
        step(); check("seq_pc4", program_counter_value, 32'd4);
        step(); check("seq_pc8", program_counter_value, 32'd8);
        step(); check("seq_pc12", program_counter_value, 32'd12);

        // Back to 8, then jal -8 -> 0
        is_jal = 1'b1; imm_j = 32'hFFFF_FFFC;
        step(); check("jal_m4", program_counter_value, 32'd8);
        imm_j = 32'hFFFF_FFF8;
        step(); check("jal_m8", program_counter_value, 32'd0);

        // jalr clears bit 0
        idle_inputs(); is_jalr = 1'b1; jalr_target = 32'h15;
        step(); check("jalr_lsb", program_counter_value, 32'h14);

        // 0x14 -> 16 via jal -4
        idle_inputs(); is_jal = 1'b1; imm_j = 32'hFFFF_FFFC;
        step(); check("jal_to16", program_counter_value, 32'd16);

        // Halt beats branch, then branch alone
        idle_inputs(); is_halt = 1'b1; branch_taken = 1'b1; branch_target = 32'd40;
        step(); check("halt_br", program_counter_value, 32'd16);
        is_halt = 1'b0;
        step(); check("branch", program_counter_value, 32'd40);

        // jal beats branch
        is_jal = 1'b1; imm_j = 32'd8; branch_target = 32'd100;
        step(); check("jal_over_br", program_counter_value, 32'd48);

        // jalr beats branch
        idle_inputs(); is_jalr = 1'b1; jalr_target = 32'h21;
        branch_taken = 1'b1; branch_target = 32'h80;
        step(); check("jalr_over_br", program_counter_value, 32'h20);

        // Halt beats jal
        idle_inputs(); is_halt = 1'b1; is_jal = 1'b1; imm_j = 32'h100;
        step(); check("halt_jal", program_counter_value, 32'h20);

        // Wrap: 0xFFFFFFFC + 4 -> 0
        idle_inputs(); is_jalr = 1'b1; jalr_target = 32'hFFFF_FFFD;
        step(); check("jalr_top", program_counter_value, 32'hFFFF_FFFC);
        idle_inputs();
        step(); check("pc_wrap", program_counter_value, 32'h0);

        // Memory: read-before-write, then new value, then alias
        address = 32'd6; memory_we = 1'b1; write_data = 32'hDEAD_BEEF;
        #1; check("mem_old", read_data, 32'h0);
        step(); check("mem_new", read_data, 32'hDEAD_BEEF);
        memory_we = 1'b0; address = 32'd70;
        #1; check("mem_alias70", read_data, 32'hDEAD_BEEF);

        // we=0 leaves memory unchanged
        address = 32'd7; write_data = 32'h5555_5555;
        step(); check("mem_nowe", read_data, 32'h0);
        // Aliased write lands on word 7
        address = 32'd71; memory_we = 1'b1; write_data = 32'h0000_1234;
        step(); memory_we = 1'b0; address = 32'd7;
        #1; check("mem_alias_wr", read_data, 32'h0000_1234);
        address = 32'd6;
        #1; check("mem6_kept", read_data, 32'hDEAD_BEEF);

        // IR one-cycle latency, not frozen by halt
        instruction_in = 32'h0020_81B3; is_halt = 1'b1;
        #1; check("ir_before", instruction_out, 32'h0000_0013);
        step();
        check("ir_after", instruction_out, 32'h0020_81B3);
        check("ir_halt_pc", program_counter_value, 32'd12);
        instruction_in = 32'h0000_0013;

        // Reset wins over jal and write
        idle_inputs();
        reset = 1'b1; is_jal = 1'b1; imm_j = 32'h40;
        memory_we = 1'b1; address = 32'd6; write_data = 32'hAAAA_AAAA;
        step();
        check("rst2_pc", program_counter_value, 32'h0);
        check("rst2_mem", read_data, 32'h0);
        address = 32'd7;
        #1; check("rst2_mem7", read_data, 32'h0);

        // First edge after reset behaves normally
        idle_inputs(); reset = 1'b0;
        step(); check("post_rst_pc", program_counter_value, 32'd4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_cpu_state_core
`default_nettype wire

// File: doc/cpu_state_core.md
CPU_STATE_CORE -- requirements
Module: cpu_state_core

Interface
REQ-001 Parameter DMEM_DEPTH, default 64: number of 32-bit data-memory words (power of two).
REQ-002 Parameter RESET_PC, default 32'h0000_0000: PC value after reset.
REQ-003 Parameter IR_RESET, default 32'h0000_0013: instruction register value after reset (addi x0,x0,0 NOP).
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 is_halt  input  1  hold PC.
REQ-007 is_jal  input  1  PC-relative jump request.
REQ-008 is_jalr  input  1  register-indirect jump request.
REQ-009 branch_taken  input  1  conditional-branch redirect request.
REQ-010 branch_target  input  32  redirect address for a taken branch.
REQ-011 jalr_target  input  32  rs1+imm for jalr.
REQ-012 imm_j  input  32  sign-extended J-type offset.
REQ-013 program_counter_value  output  32  current PC register.
REQ-014 instruction_in  input  32  fetched instruction word.
REQ-015 instruction_out  output  32  instruction register contents.
REQ-016 memory_we  input  1  data-memory write enable.
REQ-017 address  input  32  data-memory word index.
REQ-018 write_data  input  32  data-memory write word.
REQ-019 read_data  output  32  data-memory read word.

Function
REQ-020 PC next-state priority per rising edge: reset > is_halt (hold) > is_jal (PC+imm_j) > is_jalr (jalr_target with bit 0 cleared) > branch_taken (branch_target) > PC+4.
REQ-021 All PC arithmetic is 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-022 Simultaneous is_jal and branch_taken: jal wins; simultaneous is_halt with any redirect: PC holds.
REQ-023 Instruction register loads instruction_in every rising edge (no enable, halt does not freeze it); instruction_out is the registered value, one-cycle latency.
REQ-024 Data memory is an array named memory of DMEM_DEPTH 32-bit words, indexed directly by address[log2(DMEM_DEPTH)-1:0] (word index, not byte address); upper address bits ignored (aliasing wrap).
REQ-025 Read is combinational: read_data = memory[index] in the same cycle, zero latency.
REQ-026 Write is synchronous: memory_we=1 at rising edge stores write_data at index; read_data shows the new value only after that edge (read-before-write within a cycle).
REQ-027 memory_we=0: memory contents unchanged.

Reset
REQ-028 While reset=1 at a rising edge: program_counter_value <= RESET_PC, instruction_out <= IR_RESET, every memory word <= 0; all other inputs ignored, including memory_we.
REQ-029 Reset asserted mid-operation takes effect at the next rising edge regardless of halt/jump/branch/write inputs.
REQ-030 After reset deasserts, first non-reset edge applies REQ-020 normally.

Structure
REQ-031 Shared package cpu_pkg holds XLEN=32, NOP_INSTR=32'h0000_0013, HALT_INSTR=32'hFFFF_FFFF and PC step constant 4.
REQ-032 Data memory is one sub-module dmem_array (parameterised by DMEM_DEPTH); PC and IR logic live in cpu_state_core.

Verification
REQ-033 Reset 1 cycle -> PC=0, instruction_out=0x00000013, memory[6]=0; then 3 idle cycles -> PC=4,8,12.
REQ-034 PC=8, is_jal=1, imm_j=0xFFFFFFF8 -> PC=0; PC=0, is_jalr=1, jalr_target=0x15 -> PC=0x14.
REQ-035 PC=16, branch_taken=1, branch_target=40, is_halt=1 -> PC stays 16; same with is_halt=0 -> PC=40.
REQ-036 memory_we=1, address=6, write_data=0xDEADBEEF -> read_data=old value before edge, 0xDEADBEEF after; address=70 (DMEM_DEPTH 64) reads same word.
REQ-037 instruction_in=0x002081B3 at edge N -> instruction_out=0x002081B3 after edge N, unchanged by is_halt.
REQ-038 reset=1 together with is_jal=1 and memory_we=1 -> PC=0, no memory write.
